// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: M-mode CSRs, interrupt/exception/MRET classification
// of retiring instructions, and a registered fetch-redirect handshake.
module trap_ctrl #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        irq_msi,
    input  logic        irq_mti,
    input  logic        irq_mei,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic        commit_exc,
    input  logic        commit_mret,
    input  logic [31:0] commit_pc,
    input  logic [4:0]  commit_cause,
    input  logic [31:0] commit_tval,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    input  logic        csr_valid,
    input  logic        csr_we,
    output logic        csr_ready,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_hit
);
    typedef enum logic {IDLE, REDIRECT} state_t;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;

    state_t      state_q;
    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] redir_pc_q;

    logic [31:0] mip;
    logic [31:0] mstatus_rd;
    logic [31:0] pending;
    logic        irq_take;
    logic [4:0]  irq_code;
    logic        accept;
    logic        take_trap;
    logic        take_mret;
    logic        csr_wr;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;

    assign mip        = {20'b0, irq_mei, 3'b0, irq_mti, 3'b0, irq_msi, 3'b0};
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign pending    = mip & mie_q & {32{mstatus_mie_q}};
    assign irq_take   = |pending;

    // Priority MEI > MSI > MTI.
    always_comb begin
        irq_code = 5'd7;
        if (pending[11])     irq_code = 5'd11;
        else if (pending[3]) irq_code = 5'd3;
    end

    assign commit_ready = (state_q == IDLE);
    assign accept       = commit_valid && commit_ready;
    assign take_trap    = accept && (irq_take || commit_exc);
    assign take_mret    = accept && !irq_take && !commit_exc && commit_mret;
    assign csr_ready    = (state_q == IDLE) && !(take_trap || take_mret);
    assign csr_wr       = csr_valid && csr_ready && csr_we;

    assign trap_cause = irq_take ? {1'b1, 26'b0, irq_code} : {1'b0, 26'b0, commit_cause};
    // Vectored mode offsets only interrupts; exceptions always land on the base.
    assign trap_pc = (mtvec_q[0] && irq_take)
                   ? ({mtvec_q[31:2], 2'b00} + {25'b0, irq_code, 2'b00})
                   : {mtvec_q[31:2], 2'b00};

    assign redir_valid = (state_q == REDIRECT);
    assign redir_pc    = redir_pc_q;

    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = 32'h0;
        case (csr_addr)
            A_MSTATUS: csr_rdata = mstatus_rd;
            A_MIE:     csr_rdata = mie_q;
            A_MTVEC:   csr_rdata = mtvec_q;
            A_MEPC:    csr_rdata = mepc_q;
            A_MCAUSE:  csr_rdata = mcause_q;
            A_MTVAL:   csr_rdata = mtval_q;
            A_MIP:     csr_rdata = mip;
            default:   csr_hit   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0;
            mtvec_q        <= MTVEC_RESET;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            redir_pc_q     <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_trap) begin
                        mepc_q         <= commit_pc;
                        mcause_q       <= trap_cause;
                        mtval_q        <= irq_take ? 32'h0 : commit_tval;
                        mstatus_mpie_q <= mstatus_mie_q;
                        mstatus_mie_q  <= 1'b0;
                        redir_pc_q     <= trap_pc;
                        state_q        <= REDIRECT;
                    end else if (take_mret) begin
                        mstatus_mie_q  <= mstatus_mpie_q;
                        mstatus_mpie_q <= 1'b1;
                        redir_pc_q     <= mepc_q;
                        state_q        <= REDIRECT;
                    end else if (csr_wr) begin
                        case (csr_addr)
                            A_MSTATUS: begin
                                mstatus_mie_q  <= csr_wdata[3];
                                mstatus_mpie_q <= csr_wdata[7];
                            end
                            A_MIE:    mie_q    <= csr_wdata & 32'h0000_0888;
                            A_MTVEC:  mtvec_q  <= {csr_wdata[31:2], 1'b0, csr_wdata[0]};
                            A_MEPC:   mepc_q   <= {csr_wdata[31:2], 2'b00};
                            A_MCAUSE: mcause_q <= csr_wdata;
                            A_MTVAL:  mtval_q  <= csr_wdata;
                            default: ;
                        endcase
                    end
                end
                REDIRECT: begin
                    if (redir_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0000, the reset value of mtvec.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports irq_msi, irq_mti and irq_mei, input, 1 each, level machine software, timer and external interrupt lines.
REQ-005 SHALL have ports commit_valid, commit_ready, commit_exc, commit_mret: input, output, input, input, 1 each, for the retiring-instruction handshake, exception flag and MRET flag.
REQ-006 SHALL have ports commit_pc, commit_cause, commit_tval: input, widths 32, 5 and 32, carrying the retiring instruction PC, its exception code and the faulting value.
REQ-007 SHALL have ports redir_valid, redir_ready, redir_pc: output, input, output, widths 1, 1 and 32, forming the fetch redirect handshake.
REQ-008 SHALL have ports csr_valid, csr_we, csr_ready: input, input, output, 1 each, forming the CSR access handshake.
REQ-009 SHALL have ports csr_addr, csr_wdata, csr_rdata, csr_hit: input 12, input 32, output 32 and output 1.
- csr_hit=1 means csr_addr is implemented here.

Function
REQ-010 SHALL implement mstatus (0x300), mie (0x304), mtvec (0x305), mepc (0x341), mcause (0x342), mtval (0x343) and mip (0x344, read-only); other addresses give csr_hit=0 and rdata 0.
REQ-011 SHALL have mstatus writable in MIE[3] and MPIE[7] only.
- MPP[12:11] always reads 2'b11.
- All other bits read 0.
REQ-012 SHALL make mie writable only in bits 3, 7 and 11.
- mip bits 3/7/11 mirror irq_msi/irq_mti/irq_mei combinationally.
REQ-013 SHALL force mtvec[1] and mepc[1:0] to 0 on every write.
- mtvec[0] is MODE: 0 = direct, 1 = vectored.
REQ-014 SHALL provide a combinational CSR read with csr_rdata valid whenever csr_valid=1.
- A write commits at the edge where csr_valid&&csr_ready&&csr_we.
REQ-015 SHALL run an FSM with states IDLE and REDIRECT.
- commit_ready=1 only in IDLE.
- redir_valid=1 only in REDIRECT.
REQ-016 SHALL compute the pending set as mip&mie&{32{mstatus.MIE}}.
- When non-zero, the interrupt is selected by priority MEI(11) > MSI(3) > MTI(7).
REQ-017 SHALL classify each accepted commit (commit_valid&&commit_ready) in this priority order:
- interrupt pending -> interrupt trap;
- else commit_exc -> exception trap;
- else commit_mret -> MRET;
- else plain retire, with no state change.
REQ-018 SHALL, on a trap at the accept edge, update:
- mepc <= commit_pc;
- mcause <= {irq, 26'b0, code};
- mtval <= tval for exceptions, 0 for interrupts;
- MPIE <= MIE, then MIE <= 0;
- FSM -> REDIRECT.
REQ-019 SHALL set redir_pc on a trap to {mtvec[31:2],2'b00}.
- When MODE=1 and the trap is an interrupt, redir_pc adds 4*cause.
REQ-020 SHALL, on MRET, update MIE <= MPIE and MPIE <= 1, set redir_pc to mepc and move the FSM to REDIRECT.
REQ-021 SHALL register redir_pc and hold it stable with redir_valid=1 until redir_ready=1, then return to IDLE.
- Redirect latency is exactly 1 cycle after the accept edge when redir_ready is already 1.
REQ-022 SHALL drive csr_ready=(state==IDLE)&&!(commit accepted as trap/MRET in that cycle).
- Trap and MRET CSR updates therefore never collide with software writes.
REQ-023 SHALL ignore commit_exc and commit_mret when an interrupt is taken.
- The instruction is not retired.
- mepc points to it.
REQ-024 SHALL accept a commit whose commit_exc and commit_mret are both set as an exception only.
REQ-025 SHALL NOT let interrupt lines that change while in REDIRECT affect the held redir_pc.

Reset
REQ-026 SHALL, while rst_n=0, force:
- FSM=IDLE, redir_valid=0, redir_pc=0;
- mstatus MIE=0 and MPIE=0;
- mie=0, mepc=0, mcause=0, mtval=0;
- mtvec=MTVEC_RESET.
REQ-027 SHALL, on reset asserted during REDIRECT, abort the redirect immediately.
- The first post-reset cycle has commit_ready=1.

Verification
REQ-028 SHALL cover this case: commit_exc=1, cause=2, pc=0x100, tval=0xDEAD, mtvec=0x200 -> mepc=0x100, mcause=2, mtval=0xDEAD, redir_pc=0x200 one cycle later.
REQ-029 SHALL cover this case: MIE=1, mie=0x888, irq_mti=irq_mei=1, mtvec=0x201, commit at pc=0x40 -> mcause=0x8000000B, redir_pc=0x22C, MIE=0, MPIE=1.
REQ-030 SHALL cover this case: MIE=0 with irq_mei=1, then a plain commit -> retired, no redirect; a later MRET with MPIE=1 and mepc=0x80 -> MIE=1, redir_pc=0x80.
REQ-031 SHALL cover this case: redir_ready held 0 for 3 cycles -> redir_valid and redir_pc stable, commit_ready=0 and csr_ready=0 throughout.
REQ-032 SHALL cover this case: write 0xFFFFFFFF to mstatus/mie/mepc -> reads 0x1888/0x888/0xFFFFFFFC; read 0x7C0 -> csr_hit=0.
REQ-033 SHALL cover this case: rst_n pulsed low in REDIRECT -> redir_valid=0 at once, mtvec=MTVEC_RESET.
